ex_unit: RTL and testbench

Parametrised execute stage for the 4-bit-opcode processor: a register file plus ALU, load/store, branch/jump and halt logic, with a valid/ready input handshake. It sits between decode and the memory/fetch side. It issues `next_pc`/`is_jump` to fetch, `write_addr`/`data`/`is_write` to data memory, and consumes `ld_data` from memory. It adds a real reset, load wait, parametrised widths, value-based branch compare and a counted flush.

---
 rtl/ex_unit.sv | 182 ++++++++++++++++++
 tb/tb_ex_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_unit.sv
// ex_unit: execute stage with register file, ALU, load/store, branch/jump and halt.
// Optional EX_SAT_EN: add/sub/increment ops saturate as signed DW values instead of wrapping.
module ex_unit #(
    parameter int DW    = 16,
    parameter int NREG  = 16,
    parameter int PCW   = 9,
    parameter int FLUSH = 3
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                op,
    input  logic [PCW-1:0]            pc,
    input  logic [$clog2(NREG)-1:0]   rd,
    input  logic [$clog2(NREG)-1:0]   rs,
    input  logic [$clog2(NREG)-1:0]   rb,
    input  logic [7:0]                imm,
    input  logic [3:0]                disp4,
    input  logic [PCW-1:0]            disp9,
    input  logic [DW-1:0]             ld_data,
    input  logic                      ld_valid,
    output logic [PCW-1:0]            next_pc,
    output logic                      is_jump,
    output logic [PCW-1:0]            write_addr,
    output logic [DW-1:0]             data,
    output logic                      is_write,
    output logic                      halted
);

    localparam int RW = $clog2(NREG);
    localparam int CW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_LDWAIT = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_SUBI = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_LD   = 4'b1001;
    localparam logic [3:0] OP_ST   = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BGT  = 4'b1101;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [DW-1:0]  regs [NREG];
    logic [1:0]     state;
    logic [CW-1:0]  flush_cnt;
    logic [RW-1:0]  ld_rd;

    logic [DW-1:0]  rd_val, rs_val, rb_val, imm_ext;
    logic [DW-1:0]  alu_res;
    logic           alu_wr;
    logic           br_taken;
    logic [PCW-1:0] br_target, jmp_target, st_addr;

    function automatic logic [DW-1:0] addsub(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic          sub);
        logic [DW-1:0] r;
        r = sub ? a - b : a + b;
`ifdef EX_SAT_EN
        // Signed overflow: effective operand signs agree but the result sign differs.
        if (((a[DW-1] == b[DW-1]) ^ sub) && (r[DW-1] != a[DW-1]))
            r = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
        return r;
    endfunction

    assign rd_val     = regs[rd];
    assign rs_val     = regs[rs];
    assign rb_val     = regs[rb];
    assign imm_ext    = {{(DW-8){1'b0}}, imm};
    assign br_target  = pc + {{(PCW-4){disp4[3]}}, disp4};
    assign jmp_target = pc + disp9;
    assign st_addr    = rb_val[PCW-1:0] + {{(PCW-4){1'b0}}, disp4};

    assign in_ready = (state != S_LDWAIT);
    assign halted   = (state == S_HALT);

    always_comb begin
        alu_res  = '0;
        alu_wr   = 1'b1;
        br_taken = 1'b0;
        case (op)
            OP_ADD:  alu_res = addsub(rd_val, rs_val, 1'b0);
            OP_SUB:  alu_res = addsub(rd_val, rs_val, 1'b1);
            OP_AND:  alu_res = {{(DW-1){1'b0}}, (rd_val != '0) && (rs_val != '0)};
            OP_OR:   alu_res = {{(DW-1){1'b0}}, (rd_val != '0) || (rs_val != '0)};
            OP_INC:  alu_res = addsub(rd_val, {{(DW-1){1'b0}}, 1'b1}, 1'b0);
            OP_ADDI: alu_res = addsub(rd_val, imm_ext, 1'b0);
            OP_SUBI: alu_res = addsub(rd_val, imm_ext, 1'b1);
            OP_LDI:  alu_res = imm_ext;
            default: alu_wr  = 1'b0;
        endcase
        case (op)
            OP_BEQ:  br_taken = (rs_val == rb_val);
            OP_BGT:  br_taken = ($signed(rs_val) > $signed(rb_val));
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            state      <= S_RUN;
            flush_cnt  <= '0;
            ld_rd      <= '0;
            next_pc    <= '0;
            write_addr <= '0;
            data       <= '0;
            is_jump    <= 1'b0;
            is_write   <= 1'b0;
        end else begin
            is_jump  <= 1'b0;
            is_write <= 1'b0;
            case (state)
                S_RUN: begin
                    if (in_valid) begin
                        if (alu_wr) regs[rd] <= alu_res;
                        case (op)
                            OP_LD: begin
                                if (ld_valid) begin
                                    regs[rd] <= ld_data;
                                end else begin
                                    ld_rd <= rd;
                                    state <= S_LDWAIT;
                                end
                            end
                            OP_ST: begin
                                data       <= rs_val;
                                write_addr <= st_addr;
                                is_write   <= 1'b1;
                            end
                            OP_BEQ, OP_BGT: begin
                                if (br_taken) begin
                                    next_pc   <= br_target;
                                    is_jump   <= 1'b1;
                                    state     <= S_FLUSH;
                                    flush_cnt <= CW'(FLUSH - 1);
                                end
                            end
                            OP_JMP: begin
                                next_pc   <= jmp_target;
                                is_jump   <= 1'b1;
                                state     <= S_FLUSH;
                                flush_cnt <= CW'(FLUSH - 1);
                            end
                            OP_HALT: state <= S_HALT;
                            default: ;
                        endcase
                    end
                end
                S_LDWAIT: begin
                    if (ld_valid) begin
                        regs[ld_rd] <= ld_data;
                        state       <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    // Counts edges, not accepted instructions.
                    if (flush_cnt == '0) state <= S_RUN;
                    else flush_cnt <= flush_cnt - CW'(1);
                end
                S_HALT: begin
                    if (in_valid && op == OP_NOP) state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_unit.sv
// Directed testbench for ex_unit: spec-level model checked every cycle plus literal expectations.
module tb_ex_unit;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [8:0]  pc = '0;
    logic [3:0]  rd = '0, rs = '0, rb = '0;
    logic [7:0]  imm = '0;
    logic [3:0]  disp4 = '0;
    logic [8:0]  disp9 = '0;
    logic [15:0] ld_data = '0;
    logic        ld_valid = 1'b0;
    logic [8:0]  next_pc;
    logic        is_jump;
    logic [8:0]  write_addr;
    logic [15:0] data;
    logic        is_write;
    logic        halted;

    ex_unit #(.DW(16), .NREG(16), .PCW(9), .FLUSH(3)) dut (
        .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .pc(pc), .rd(rd), .rs(rs), .rb(rb), .imm(imm),
        .disp4(disp4), .disp9(disp9), .ld_data(ld_data), .ld_valid(ld_valid),
        .next_pc(next_pc), .is_jump(is_jump), .write_addr(write_addr),
        .data(data), .is_write(is_write), .halted(halted)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: mode names, register values as ints, remaining discarded edges.
    localparam int M_RUN = 0, M_LDW = 1, M_FL = 2, M_HALT = 3;
    int m_r [16];
    int m_mode, m_flush_left, m_ldrd;
    int e_next_pc, e_waddr, e_data, e_jump, e_write;

    function automatic int sgn(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int fit(input int v);
`ifdef EX_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v & 32'h0000FFFF;
    endfunction

    function automatic int wrap9(input int v);
        return ((v % 512) + 512) % 512;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        m_mode = M_RUN; m_flush_left = 0; m_ldrd = 0;
        e_next_pc = 0; e_waddr = 0; e_data = 0; e_jump = 0; e_write = 0;
    endtask

    task automatic m_exec();
        int a, b, c, d4s, d9s;
        a = m_r[rd]; b = m_r[rs]; c = m_r[rb];
        d4s = (disp4 >= 8) ? int'(disp4) - 16 : int'(disp4);
        d9s = (disp9 >= 256) ? int'(disp9) - 512 : int'(disp9);
        case (op)
            4'd1:  m_r[rd] = fit(sgn(a) + sgn(b));
            4'd2:  m_r[rd] = fit(sgn(a) - sgn(b));
            4'd3:  m_r[rd] = (a != 0 && b != 0) ? 1 : 0;
            4'd4:  m_r[rd] = (a != 0 || b != 0) ? 1 : 0;
            4'd5:  m_r[rd] = fit(sgn(a) + int'(imm));
            4'd6:  m_r[rd] = fit(sgn(a) - int'(imm));
            4'd7:  m_r[rd] = fit(sgn(a) + 1);
            4'd8:  m_r[rd] = int'(imm);
            4'd9:  if (ld_valid) m_r[rd] = int'(ld_data);
                   else begin m_ldrd = rd; m_mode = M_LDW; end
            4'd10: begin e_data = b; e_waddr = wrap9(c + int'(disp4)); e_write = 1; end
            4'd12, 4'd13:
                if ((op == 4'd12) ? (b == c) : (sgn(b) > sgn(c))) begin
                    e_next_pc = wrap9(int'(pc) + d4s); e_jump = 1;
                    m_mode = M_FL; m_flush_left = 3;
                end
            4'd14: begin
                e_next_pc = wrap9(int'(pc) + d9s); e_jump = 1;
                m_mode = M_FL; m_flush_left = 3;
            end
            4'd15: m_mode = M_HALT;
            default: ;
        endcase
    endtask

    task automatic m_edge();
        e_jump = 0; e_write = 0;
        if (rst) begin m_reset(); return; end
        case (m_mode)
            M_RUN:  if (in_valid) m_exec();
            M_LDW:  if (ld_valid) begin m_r[m_ldrd] = int'(ld_data); m_mode = M_RUN; end
            M_FL:   begin m_flush_left--; if (m_flush_left == 0) m_mode = M_RUN; end
            default: if (in_valid && op == 4'd0) m_mode = M_RUN;
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge ck) begin
        if (chk_en) begin
            chk("in_ready",   int'(in_ready),   (m_mode != M_LDW) ? 1 : 0);
            chk("halted",     int'(halted),     (m_mode == M_HALT) ? 1 : 0);
            chk("is_jump",    int'(is_jump),    e_jump);
            chk("is_write",   int'(is_write),   e_write);
            chk("next_pc",    int'(next_pc),    e_next_pc);
            chk("write_addr", int'(write_addr), e_waddr);
            chk("data",       int'(data),       e_data);
        end
    end

    task automatic step();
        @(posedge ck);
        m_edge();
        @(negedge ck);
        #1;
    endtask

    task automatic ins(input logic [3:0] o, input int a_rd, input int a_rs,
                       input int a_rb, input int a_imm);
        in_valid = 1'b1; ld_valid = 1'b0;
        op = o; rd = 4'(a_rd); rs = 4'(a_rs); rb = 4'(a_rb); imm = 8'(a_imm);
        step();
    endtask

    task automatic load_hit(input int a_rd, input int val);
        ld_data = 16'(val);
        in_valid = 1'b1; op = 4'd9; rd = 4'(a_rd);
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic store(input int a_rs, input int a_rb, input int d4);
        disp4 = 4'(d4);
        ins(4'd10, 0, a_rs, a_rb, 0);
        disp4 = 4'd0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; op = 4'd0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_reset();
        chk_en = 1'b1;
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_halted",   int'(halted), 0);
        rst = 1'b0;
        idle(1);

        // Immediate loads and register add
        ins(4'd8, 2, 0, 0, 5);
        ins(4'd8, 3, 0, 0, 7);
        ins(4'd1, 2, 3, 0, 0);
        chk("add_no_jump", int'(is_jump), 0);
        store(2, 0, 0);
        chk("add_r2", int'(data), 12);

        // Increment across the signed boundary
        load_hit(1, 16'h7FFF);
        ins(4'd7, 1, 0, 0, 0);
        store(1, 0, 0);
`ifdef EX_SAT_EN
        chk("inc_r1", int'(data), 16'h7FFF);
`else
        chk("inc_r1", int'(data), 16'h8000);
`endif

        // Load miss: two wait cycles then data
        ld_valid = 1'b0;
        in_valid = 1'b1; op = 4'd9; rd = 4'd6;
        step();
        chk("ldw_ready0", int'(in_ready), 0);
        op = 4'd1; rd = 4'd2; rs = 4'd3;
        step();
        chk("ldw_ready1", int'(in_ready), 0);
        ld_data = 16'hBEEF; ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        chk("ldw_ready2", int'(in_ready), 1);
        store(6, 0, 0);
        chk("ld_r6", int'(data), 16'hBEEF);
        store(2, 0, 0);
        chk("ldw_r2_kept", int'(data), 12);

        // Store address wrap
        load_hit(4, 16'h01FE);
        ins(4'd8, 5, 0, 0, 8'h55);
        store(5, 4, 3);
        chk("st_addr", int'(write_addr), 1);
        chk("st_data", int'(data), 16'h55);
        chk("st_pulse", int'(is_write), 1);
        idle(1);
        chk("st_pulse_end", int'(is_write), 0);

        // Jump with valid held high: three discarded, fourth executes
        pc = 9'd10; disp9 = 9'h1FC;
        ins(4'd14, 0, 0, 0, 0);
        chk("jmp_pc", int'(next_pc), 6);
        chk("jmp_pulse", int'(is_jump), 1);
        ins(4'd8, 7, 0, 0, 8'h11);
        chk("jmp_pulse_end", int'(is_jump), 0);
        ins(4'd8, 7, 0, 0, 8'h22);
        ins(4'd8, 7, 0, 0, 8'h33);
        ins(4'd8, 8, 0, 0, 8'h44);
        store(7, 0, 0);
        chk("flush_r7", int'(data), 0);
        store(8, 0, 0);
        chk("flush_r8", int'(data), 16'h44);

        // Signed BGT taken, flush with valid low, then not taken on negative
        pc = 9'd20; disp4 = 4'd5;
        ins(4'd13, 0, 2, 3, 0);
        chk("bgt_pc", int'(next_pc), 25);
        idle(3);
        disp4 = 4'd0;
        ins(4'd6, 9, 0, 0, 1);
        ins(4'd13, 0, 9, 3, 0);
        chk("bgt_neg_nt", int'(is_jump), 0);
        pc = 9'h100; disp4 = 4'hE;
        ins(4'd12, 0, 3, 3, 0);
        chk("beq_pc", int'(next_pc), 9'h0FE);
        idle(3);
        disp4 = 4'd0;
        ins(4'd3, 10, 2, 0, 0);
        ins(4'd4, 11, 2, 0, 0);
        store(11, 0, 0);
        chk("or_r11", int'(data), 1);

        // Halt drops everything but NOP
        ins(4'd15, 0, 0, 0, 0);
        ins(4'd5, 2, 0, 0, 9);
        chk("halted", int'(halted), 1);
        ins(4'd5, 2, 0, 0, 9);
        ins(4'd0, 0, 0, 0, 0);
        chk("unhalted", int'(halted), 0);
        store(2, 0, 0);
        chk("halt_r2", int'(data), 12);

        // Reset in the middle of a flush
        pc = 9'd40; disp9 = 9'd3;
        ins(4'd14, 0, 0, 0, 0);
        idle(1);
        #1;
        rst = 1'b1;
        m_reset();
        step();
        chk("rst_fl_pc", int'(next_pc), 0);
        rst = 1'b0;
        ins(4'd8, 1, 0, 0, 3);
        store(1, 0, 0);
        chk("post_rst_r1", int'(data), 3);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
